uart_wrapper: RTL and testbench

UART_WRAPPER -- requirements
Module: uart_wrapper

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx.sv | 107 ++++++++++
 rtl/uart_wrapper.sv | 139 +++++++++++++
 tb/tb_uart_wrapper.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command wrapper.
// Holds the RX/assembly/TX state encodings and the baud divisor default.
package uart_pkg;

    localparam int BAUD_DIV_DEF = 2604;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        ASM_HIGH,
        ASM_LOW
    } asm_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_XMIT
    } tx_state_e;

    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receive bit engine: synchroniser, start-bit qualification,
// 8N1 deserialisation and stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_err,
    output logic       rx_acc
);

    localparam int CW = cnt_w(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_rdy  = 1'b0;
        rx_err  = 1'b0;
        rx_acc  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    // a line already back high mid-start-bit is noise
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        rx_acc  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    rx_rdy  = sync2_q;
                    rx_err  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data = shift_q;

endmodule

// File: rtl/uart_wrapper.sv
// Full-duplex UART front end: pairs received bytes into a 16-bit
// command and serialises single response bytes back to the host.
module uart_wrapper
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int CW = cnt_w(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          rx_err;
    logic          rx_acc;

    asm_state_e    asm_q, asm_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          resp_sent_q, resp_sent_d;

    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .rx_data(rx_data),
        .rx_rdy (rx_rdy),
        .rx_err (rx_err),
        .rx_acc (rx_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= ASM_HIGH;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            resp_sent_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // clear first so that a completing second byte overrides it
    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy || rx_acc) begin
            cmd_rdy_d = 1'b0;
        end
        unique case (asm_q)
            ASM_HIGH: begin
                if (rx_rdy) begin
                    cmd_d[15:8] = rx_data;
                    asm_d       = ASM_LOW;
                end
            end
            ASM_LOW: begin
                if (rx_rdy) begin
                    cmd_d[7:0] = rx_data;
                    cmd_rdy_d  = 1'b1;
                    asm_d      = ASM_HIGH;
                end else if (rx_err) begin
                    asm_d = ASM_HIGH;
                end
            end
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        resp_sent_d = resp_sent_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_cnt_d    = '0;
                    tx_bit_d    = '0;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == FULL) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d  = TX_IDLE;
                        tx_shift_d  = '0;
                        tx_bit_d    = '0;
                        resp_sent_d = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign TX        = (tx_state_q == TX_XMIT) ? tx_shift_q[0] : 1'b1;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed plus randomised checks of uart_wrapper at BAUD_DIV=16
// against a byte-level model of command assembly and TX framing.
module tb_uart_wrapper;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_cmd = 16'h0000;
    logic        exp_rdy = 1'b0;
    logic        have_high = 1'b0;
    logic        mid_rdy;

    uart_wrapper #(
        .BAUD_DIV(BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one 8N1 frame; clr_at pulses clr_cmd_rdy in that bit-clock slot
    task automatic send_byte(input logic [7:0] d, input logic stop,
                             input int clr_at);
        logic [9:0] fr;
        int n;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            RX = fr[b];
            for (int c = 0; c < BD; c++) begin
                @(negedge clk);
                n = b * BD + c + 1;
                if (n == 150) mid_rdy = cmd_rdy;
                clr_cmd_rdy = (n == clr_at);
            end
        end
        clr_cmd_rdy = 1'b0;
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic stop,
                           input int clr_at);
        send_byte(d, stop, clr_at);
        exp_rdy = 1'b0;
        if (!stop) begin
            have_high = 1'b0;
        end else if (!have_high) begin
            exp_cmd[15:8] = d;
            have_high = 1'b1;
        end else begin
            exp_cmd[7:0] = d;
            have_high = 1'b0;
            exp_rdy = 1'b1;
        end
        check("rdy_before_stop", {15'd0, mid_rdy}, 16'd0);
        check("cmd", cmd, exp_cmd);
        check("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, exp_rdy});
    endtask

    task automatic clr_pulse();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("clr_cmd_kept", cmd, exp_cmd);
    endtask

    // checks first and last clock of every bit, then resp_sent timing
    task automatic tx_frame(input logic [7:0] r, input bit inject);
        logic [9:0] fr;
        fr = {1'b1, r, 1'b0};
        resp = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'($urandom);
        for (int n = 1; n <= 175; n++) begin
            if (n == 1)
                check("resp_sent_clr", {15'd0, resp_sent}, 16'd0);
            if (n <= 10 * BD && ((n - 1) % BD == 0 || n % BD == 0))
                check("tx_bit", {15'd0, TX},
                      {15'd0, fr[(n - 1) / BD]});
            if (n == 10 * BD)
                check("resp_sent_pre", {15'd0, resp_sent}, 16'd0);
            if (n == 10 * BD + 1)
                check("resp_sent", {15'd0, resp_sent}, 16'd1);
            if (n == 175) begin
                check("tx_idle", {15'd0, TX}, 16'd1);
                check("resp_sent_hold", {15'd0, resp_sent}, 16'd1);
            end
            if (inject && n == 40) begin
                resp = 8'h00;
                send_resp = 1'b1;
            end else begin
                send_resp = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] bits55;
        bits55 = 8'h55;
        mid_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {15'd0, TX}, 16'd1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("rst_resp_sent", {15'd0, resp_sent}, 16'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        rx_byte(8'h41, 1'b1, 0);
        rx_byte(8'h23, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("rdy_hold", {15'd0, cmd_rdy}, 16'd1);
        clr_pulse();

        tx_frame(8'hA5, 1'b0);
        tx_frame(8'hA5, 1'b1);

        rx_byte(8'h12, 1'b0, 0);
        rx_byte(8'hAB, 1'b1, 0);
        rx_byte(8'hCD, 1'b1, 0);

        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rdy", {15'd0, cmd_rdy}, {15'd0, exp_rdy});
        check("glitch_cmd", cmd, exp_cmd);

        for (int i = 0; i < 4; i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            rx_byte(hi, 1'b1, 0);
            if (i == 2) begin
                rx_byte(8'($urandom), 1'b0, 0);
                rx_byte(8'($urandom), 1'b1, 0);
            end
            rx_byte(lo, 1'b1, (i == 1) ? 154 : 0);
        end
        for (int i = 0; i < 2; i++) begin
            tx_frame(8'($urandom), 1'b0);
        end

        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (30) @(negedge clk);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            RX = bits55[b];
            repeat (BD) @(negedge clk);
        end
        RX = bits55[3];
        repeat (BD / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cmd = 16'h0000;
        exp_rdy = 1'b0;
        have_high = 1'b0;
        check("mid_rst_tx", {15'd0, TX}, 16'd1);
        check("mid_rst_cmd", cmd, 16'h0000);
        check("mid_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("mid_rst_sent", {15'd0, resp_sent}, 16'd0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_tx", {15'd0, TX}, 16'd1);
        rx_byte(8'h55, 1'b1, 0);
        rx_byte(8'hAA, 1'b1, 0);
        check("final_cmd", cmd, 16'h55AA);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
